// File: rtl/wash_phase_sequencer_if.sv
// Control/status bundle between the wash state controller and the phase sequencer.
interface wash_phase_sequencer_if #(
  parameter int NUM_PHASES = 4,
  parameter int PHASE_W    = 8
);
  localparam int IDX_W = $clog2(NUM_PHASES);
  localparam int TOT_W = PHASE_W + $clog2(NUM_PHASES);

  logic                          load;
  logic [NUM_PHASES*PHASE_W-1:0] durations;
  logic                          start;
  logic                          pause;
  logic                          abort;
  logic                          tick;
  logic                          busy;
  logic                          paused;
  logic                          finished;
  logic                          phase_done;
  logic [IDX_W-1:0]              phase_idx;
  logic [PHASE_W-1:0]            phase_remaining;
  logic [TOT_W-1:0]              total_remaining;

  modport master (
    output load, durations, start, pause, abort,
    input  tick, busy, paused, finished, phase_done,
           phase_idx, phase_remaining, total_remaining
  );

  modport slave (
    input  load, durations, start, pause, abort,
    output tick, busy, paused, finished, phase_done,
           phase_idx, phase_remaining, total_remaining
  );
endinterface

// File: rtl/wash_phase_sequencer.sv
// Countdown sequencer: start delay, NUM_PHASES back-to-back timed phases, finish hold,
// with pause/resume, abort and one-cycle skip of zero-length phases.
module wash_phase_sequencer #(
  parameter int NUM_PHASES  = 4,
  parameter int PHASE_W     = 8,
  parameter int TICK_DIV    = 5000,
  parameter int START_DELAY = 2,
  parameter int FINISH_HOLD = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  wash_phase_sequencer_if.slave  bus
);
  localparam int IDX_W    = $clog2(NUM_PHASES);
  localparam int TOT_W    = PHASE_W + $clog2(NUM_PHASES);
  localparam int PS_W     = $clog2(TICK_DIV);
  localparam int HOLD_MAX = (START_DELAY > FINISH_HOLD) ? START_DELAY : FINISH_HOLD;
  localparam int CNT_W    = $clog2(HOLD_MAX + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);

  typedef enum logic [2:0] {IDLE, ARMED, RUN, PAUSED, FINISH} state_t;

  state_t             state;
  state_t             resume_state;
  logic [PS_W-1:0]    ps;
  logic               tick;
  logic [CNT_W-1:0]   cnt;
  logic [PHASE_W-1:0] dur [NUM_PHASES];
  logic [TOT_W-1:0]   dur_sum;

  assign tick          = (ps == PS_W'(TICK_DIV - 1));
  assign bus.tick      = tick;
  assign bus.busy      = (state == ARMED) || (state == RUN) || (state == PAUSED);
  assign bus.paused    = (state == PAUSED);
  assign bus.finished  = (state == FINISH);

  // Free-running prescaler: keeps counting through pause so the second grid never drifts.
  always_ff @(posedge clk) begin
    if (rst || tick) ps <= '0;
    else             ps <= ps + 1'b1;
  end

  always_comb begin
    dur_sum = '0;
    for (int unsigned i = 0; i < NUM_PHASES; i++) dur_sum = dur_sum + TOT_W'(dur[i]);
  end

  // cnt serves as the start-delay counter in ARMED and the hold counter in FINISH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      resume_state        <= IDLE;
      cnt                 <= '0;
      bus.phase_done      <= 1'b0;
      bus.phase_idx       <= '0;
      bus.phase_remaining <= '0;
      bus.total_remaining <= '0;
      for (int unsigned i = 0; i < NUM_PHASES; i++) dur[i] <= '0;
    end else begin
      bus.phase_done <= 1'b0;
      if (bus.abort) begin
        state               <= IDLE;
        bus.phase_idx       <= '0;
        bus.phase_remaining <= '0;
        bus.total_remaining <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (!bus.pause) begin
              if (bus.load)
                for (int unsigned i = 0; i < NUM_PHASES; i++)
                  dur[i] <= bus.durations[i*PHASE_W +: PHASE_W];
              if (bus.start) begin
                state <= ARMED;
                cnt   <= CNT_W'(START_DELAY);
              end
            end
          end
          ARMED: begin
            if (bus.pause) begin
              state        <= PAUSED;
              resume_state <= ARMED;
            end else if (tick) begin
              cnt <= cnt - 1'b1;
              if (cnt == CNT_W'(1)) begin
                state               <= RUN;
                bus.phase_idx       <= '0;
                bus.phase_remaining <= dur[0];
                bus.total_remaining <= dur_sum;
              end
            end
          end
          RUN: begin
            if (bus.pause) begin
              state        <= PAUSED;
              resume_state <= RUN;
            end else if (bus.phase_remaining == '0) begin
              bus.phase_done <= 1'b1;
              if (bus.phase_idx == LAST_IDX) begin
                state <= FINISH;
                cnt   <= CNT_W'(FINISH_HOLD);
              end else begin
                bus.phase_idx       <= bus.phase_idx + 1'b1;
                bus.phase_remaining <= dur[bus.phase_idx + 1'b1];
              end
            end else if (tick) begin
              bus.phase_remaining <= bus.phase_remaining - 1'b1;
              if (bus.total_remaining != '0)
                bus.total_remaining <= bus.total_remaining - 1'b1;
            end
          end
          PAUSED: begin
            if (!bus.pause) state <= resume_state;
          end
          FINISH: begin
            if (tick) begin
              cnt <= cnt - 1'b1;
              if (cnt == CNT_W'(1)) begin
                state         <= IDLE;
                bus.phase_idx <= '0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
